sys_arr_acc: RTL and testbench

- Output accumulator directly downstream of the systolic-array adder tree; consumes the single root result of the final add_tree stage.
- Root results arrive as DEPTH interleaved output channels. Each channel is accumulated over a configurable number of K-tiles (partial sums).
- Each finished sum is pushed into a small show-ahead output FIFO with valid/ready handshake.
- Upstream has no backpressure of its own, so a stall output is provided for gating the upstream clk_en.

---
 rtl/sys_arr_acc_if.sv | 21 ++
 rtl/sys_arr_acc.sv | 161 ++++++++++++++++
 tb/tb_sys_arr_acc.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_arr_acc_if.sv
// Valid/ready word stream between the adder tree, the accumulator
// and its consumer.
interface sys_arr_acc_if #(
  parameter int W = 32
);
  logic [W-1:0] word;
  logic         val;
  logic         rdy;

  modport master (
    output word,
    output val,
    input  rdy
  );

  modport slave (
    input  word,
    input  val,
    output rdy
  );
endinterface

// File: rtl/sys_arr_acc.sv
// Interleaved K-tile accumulator behind the systolic adder tree,
// with a show-ahead result FIFO and upstream stall request.
module sys_arr_acc #(
  parameter int DATA_WDT     = 32,
  parameter int DEPTH        = 8,
  parameter int TILE_CNT_WDT = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int STALL_THR    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic                    acc_clr,
  input  logic [TILE_CNT_WDT-1:0] acc_tile_cfg,
  sys_arr_acc_if.slave            acc_in,
  sys_arr_acc_if.master           acc_out,
  output logic                    acc_stall,
  output logic                    acc_sat,
  output logic                    acc_ovf
);
  localparam int SW = $clog2(DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = FW + 1;
  localparam int W  = DATA_WDT;
  localparam int TW = TILE_CNT_WDT;

  localparam logic [W-1:0] MAX_W = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_W = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] FD_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] THR_C = CW'(STALL_THR);
  localparam logic [SW-1:0] SLOT_LAST = SW'(DEPTH - 1);

  logic [W-1:0]  slot_q [DEPTH];
  logic [W-1:0]  slot_d [DEPTH];
  logic [W-1:0]  mem_q  [FIFO_DEPTH];
  logic [W-1:0]  mem_d  [FIFO_DEPTH];
  logic [SW-1:0] slot_ptr_q, slot_ptr_d;
  logic [TW-1:0] tile_ptr_q, tile_ptr_d;
  logic [TW-1:0] tile_cfg_q, tile_cfg_d;
  logic [FW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  out_word_q, out_word_d;
  logic          stall_q, stall_d;
  logic          sat_q, sat_d;
  logic          ovf_q, ovf_d;

  logic [SW-1:0] slot_e;
  logic [TW-1:0] tile_e;
  logic [TW-1:0] cfg_e;
  logic [TW-1:0] cfg_last;
  logic [W-1:0]  base;
  logic [W:0]    sum_x;
  logic [W-1:0]  sum_w;
  logic          sat_hit;
  logic          is_final;
  logic          push_req;
  logic          push;
  logic          pop;

  // A clear starts the new job in this very cycle.
  always_comb begin
    slot_e = acc_clr ? '0 : slot_ptr_q;
    tile_e = acc_clr ? '0 : tile_ptr_q;
    cfg_e  = acc_clr ? acc_tile_cfg : tile_cfg_q;
    if (cfg_e == '0) cfg_e = TW'(1);
    cfg_last = cfg_e - TW'(1);
    base     = (tile_e == '0) ? '0 : slot_q[slot_e];
    sum_x    = {base[W-1], base} + {acc_in.word[W-1], acc_in.word};
    sat_hit  = sum_x[W] ^ sum_x[W-1];
    sum_w    = sat_hit ? (sum_x[W] ? MIN_W : MAX_W) : sum_x[W-1:0];
    is_final = (tile_e == cfg_last);
  end

  always_comb begin
    slot_d     = slot_q;
    mem_d      = mem_q;
    slot_ptr_d = slot_ptr_q;
    tile_ptr_d = tile_ptr_q;
    tile_cfg_d = tile_cfg_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    out_word_d = out_word_q;
    stall_d    = stall_q;
    sat_d      = sat_q;
    ovf_d      = ovf_q;
    push_req   = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    if (clk_en) begin
      pop = (cnt_q != '0) && acc_out.rdy;
      if (acc_clr) begin
        slot_d     = '{default: '0};
        slot_ptr_d = '0;
        tile_ptr_d = '0;
        tile_cfg_d = cfg_e;
        sat_d      = 1'b0;
        ovf_d      = 1'b0;
      end
      if (acc_in.val) begin
        if (sat_hit) sat_d = 1'b1;
        slot_d[slot_e] = is_final ? '0 : sum_w;
        push_req   = is_final;
        slot_ptr_d = slot_e + SW'(1);
        if (slot_e == SLOT_LAST)
          tile_ptr_d = is_final ? '0 : tile_e + TW'(1);
        else
          tile_ptr_d = tile_e;
      end
      // A full FIFO still accepts a push when the head leaves this cycle.
      push = push_req && ((cnt_q != FD_C) || pop);
      if (push_req && !push) ovf_d = 1'b1;
      if (push) begin
        mem_d[wr_ptr_q] = sum_w;
        wr_ptr_d = wr_ptr_q + FW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + FW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      if (cnt_d != '0) out_word_d = mem_d[rd_ptr_d];
      stall_d = (FD_C - cnt_d) <= THR_C;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      slot_q     <= '{default: '0};
      mem_q      <= '{default: '0};
      slot_ptr_q <= '0;
      tile_ptr_q <= '0;
      tile_cfg_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      out_word_q <= '0;
      stall_q    <= 1'b0;
      sat_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      mem_q      <= mem_d;
      slot_ptr_q <= slot_ptr_d;
      tile_ptr_q <= tile_ptr_d;
      tile_cfg_q <= tile_cfg_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      out_word_q <= out_word_d;
      stall_q    <= stall_d;
      sat_q      <= sat_d;
      ovf_q      <= ovf_d;
    end
  end

  assign acc_in.rdy   = ~stall_q;
  assign acc_out.word = out_word_q;
  assign acc_out.val  = (cnt_q != '0);
  assign acc_stall    = stall_q;
  assign acc_sat      = sat_q;
  assign acc_ovf      = ovf_q;
endmodule

// File: tb/tb_sys_arr_acc.sv
// Scenario bench for sys_arr_acc: expected results are queued as
// stimulus is driven and checked as the FIFO head is consumed.
module tb_sys_arr_acc;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_en;
  logic       acc_clr;
  logic [7:0] acc_tile_cfg;
  logic       acc_stall;
  logic       acc_sat;
  logic       acc_ovf;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  sys_arr_acc_if #(.W(32)) in_if ();
  sys_arr_acc_if #(.W(32)) out_if ();

  sys_arr_acc #(
    .DATA_WDT(32), .DEPTH(8), .TILE_CNT_WDT(8),
    .FIFO_DEPTH(4), .STALL_THR(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clk_en(clk_en),
    .acc_clr(acc_clr),
    .acc_tile_cfg(acc_tile_cfg),
    .acc_in(in_if.slave),
    .acc_out(out_if.master),
    .acc_stall(acc_stall),
    .acc_sat(acc_sat),
    .acc_ovf(acc_ovf)
  );

  always #5 clk = ~clk;

  // Consumer side: a head is taken on the coming edge.
  always @(negedge clk) begin
    if (!rst_n && clk_en && out_if.val && out_if.rdy) begin
      logic [31:0] exp;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got %h required none", out_if.word);
      end else begin
        exp = sb.pop_front();
        if (out_if.word !== exp) begin
          errors++;
          $display("FAIL pop_word got %h required %h", out_if.word, exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] w);
    in_if.word = w;
    in_if.val  = 1'b1;
    step();
    in_if.val  = 1'b0;
  endtask

  task automatic clr(input logic [7:0] cfg);
    acc_clr = 1'b1;
    acc_tile_cfg = cfg;
    step();
    acc_clr = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; clk_en = 1'b1; acc_clr = 1'b0; acc_tile_cfg = '0;
    in_if.word = '0; in_if.val = 1'b0; out_if.rdy = 1'b0;
    step(); step();
    rst_n = 1'b0;
    checks++;
    if ({out_if.val, acc_stall, acc_sat, acc_ovf} !== 4'b0 ||
        out_if.word !== 32'h0) begin
      errors++;
      $display("FAIL reset_state got val%b st%b sat%b ovf%b w%h required 0",
               out_if.val, acc_stall, acc_sat, acc_ovf, out_if.word);
    end
  endtask

  task automatic test_clr_accum();
    out_if.rdy = 1'b1;
    clr(8'd3);
    for (int k = 0; k < 8; k++) sb.push_back(32'd3);
    for (int i = 0; i < 16; i++) feed(32'd1);
    checks++;
    if (out_if.val !== 1'b0) begin
      errors++;
      $display("FAIL early_val got %b required 0", out_if.val);
    end
    feed(32'd1);
    checks++;
    if (out_if.val !== 1'b1 || out_if.word !== 32'd3) begin
      errors++;
      $display("FAIL first_latency got val%b w%h required val1 w3",
               out_if.val, out_if.word);
    end
    for (int i = 0; i < 7; i++) feed(32'd1);
    drain();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL clr_drain got %0d left required 0", sb.size());
    end
  endtask

  task automatic test_signed();
    out_if.rdy = 1'b1;
    clr(8'd2);
    for (int k = 0; k < 8; k++) sb.push_back(32'(-k));
    for (int k = 0; k < 8; k++) feed(32'(k));
    for (int k = 0; k < 8; k++) feed(32'(-2 * k));
    drain();
    checks++;
    if (sb.size() != 0 || acc_sat !== 1'b0 || acc_ovf !== 1'b0) begin
      errors++;
      $display("FAIL signed_flags got left%0d sat%b ovf%b required 0 0 0",
               sb.size(), acc_sat, acc_ovf);
    end
  endtask

  task automatic test_saturation();
    out_if.rdy = 1'b1;
    clr(8'd2);
    sb.push_back(32'h7FFF_FFFF);
    sb.push_back(32'h8000_0000);
    for (int k = 2; k < 8; k++) sb.push_back(32'h0);
    feed(32'h7FFF_FFF0);
    feed(32'h8000_0000);
    for (int k = 2; k < 8; k++) feed(32'h0);
    checks++;
    if (acc_sat !== 1'b0) begin
      errors++;
      $display("FAIL sat_early got %b required 0", acc_sat);
    end
    feed(32'h0000_0020);
    feed(32'hFFFF_FFFF);
    for (int k = 2; k < 8; k++) feed(32'h0);
    drain();
    checks++;
    if (acc_sat !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL sat_flag got sat%b left%0d required sat1 left0",
               acc_sat, sb.size());
    end
  endtask

  task automatic test_backpressure();
    out_if.rdy = 1'b0;
    clr(8'd1);
    for (int k = 1; k <= 4; k++) sb.push_back(32'(k));
    sb.push_back(32'd6);
    feed(32'd1);
    checks++;
    if (acc_stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_after1 got %b required 0", acc_stall);
    end
    feed(32'd2);
    checks++;
    if (acc_stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_after2 got %b required 1", acc_stall);
    end
    feed(32'd3);
    feed(32'd4);
    checks++;
    if (acc_ovf !== 1'b0 || out_if.word !== 32'd1) begin
      errors++;
      $display("FAIL full_state got ovf%b w%h required ovf0 w1",
               acc_ovf, out_if.word);
    end
    feed(32'd5);
    checks++;
    if (acc_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag got %b required 1", acc_ovf);
    end
    out_if.rdy = 1'b1;
    feed(32'd6);
    checks++;
    if (acc_stall !== 1'b1 || out_if.word !== 32'd2) begin
      errors++;
      $display("FAIL push_pop_full got st%b w%h required st1 w2",
               acc_stall, out_if.word);
    end
    drain();
    step();
    checks++;
    if (sb.size() != 0 || out_if.val !== 1'b0 || acc_stall !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got left%0d val%b st%b required 0 0 0",
               sb.size(), out_if.val, acc_stall);
    end
  endtask

  task automatic test_clken_clr();
    out_if.rdy = 1'b0;
    clr(8'd1);
    sb.push_back(32'd7);
    feed(32'd7);
    clk_en = 1'b0;
    in_if.word = 32'd100; in_if.val = 1'b1; out_if.rdy = 1'b1;
    step(); step(); step();
    checks++;
    if (out_if.val !== 1'b1 || out_if.word !== 32'd7) begin
      errors++;
      $display("FAIL clken_hold got val%b w%h required val1 w7",
               out_if.val, out_if.word);
    end
    in_if.val = 1'b0; clk_en = 1'b1;
    step();
    checks++;
    if (out_if.val !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL clken_nopush got val%b left%0d required 0 0",
               out_if.val, sb.size());
    end
    sb.push_back(32'd9);
    acc_clr = 1'b1; acc_tile_cfg = 8'd0;
    feed(32'd9);
    acc_clr = 1'b0;
    checks++;
    if (out_if.val !== 1'b1 || out_if.word !== 32'd9) begin
      errors++;
      $display("FAIL clr_cfg0 got val%b w%h required val1 w9",
               out_if.val, out_if.word);
    end
    drain();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL clr_cfg0_drain got %0d left required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_job();
    out_if.rdy = 1'b0;
    clr(8'd1);
    for (int k = 1; k <= 5; k++) feed(32'(k));
    clk_en = 1'b0;
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    clk_en = 1'b1;
    checks++;
    if ({out_if.val, acc_stall, acc_sat, acc_ovf} !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset got val%b st%b sat%b ovf%b required 0",
               out_if.val, acc_stall, acc_sat, acc_ovf);
    end
    out_if.rdy = 1'b1;
    sb.push_back(32'd5);
    feed(32'd5);
    drain();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL post_reset got %0d left required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_clr_accum();
    test_signed();
    test_saturation();
    test_backpressure();
    test_clken_clr();
    test_reset_mid_job();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
